seg7_scan: RTL and testbench

//   Time-multiplexed driver for an N-digit common-anode 7-segment display.

---
 rtl/seg7_scan_pkg.sv | 36 +++
 rtl/seg7_scan_hex_to_seg7.sv | 15 +
 rtl/seg7_scan.sv | 153 +++++++++++++++
 tb/tb_seg7_scan.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/seg7_scan_pkg.sv
// Shared definitions for the 7-segment scan driver: segment constants,
// hex glyph lookup and the scan-state encoding.
package seg7_scan_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

  // Active-low {dp,g,f,e,d,c,b,a}; dp bit is left off here.
  function automatic logic [7:0] hex_glyph(input logic [3:0] nibble);
    logic [7:0] g;
    case (nibble)
      4'h0: g = 8'hC0;
      4'h1: g = 8'hF9;
      4'h2: g = 8'hA4;
      4'h3: g = 8'hB0;
      4'h4: g = 8'h99;
      4'h5: g = 8'h92;
      4'h6: g = 8'h82;
      4'h7: g = 8'hF8;
      4'h8: g = 8'h80;
      4'h9: g = 8'h90;
      4'hA: g = 8'h88;
      4'hB: g = 8'h83;
      4'hC: g = 8'hC6;
      4'hD: g = 8'hA1;
      4'hE: g = 8'h86;
      default: g = 8'h8E;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg7_scan_hex_to_seg7.sv
// Combinational nibble + decimal point to active-low 7-segment pattern.
module hex_to_seg7
  import seg7_scan_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] seg
);

  always_comb begin
    seg    = hex_glyph(nibble);
    seg[7] = ~dp;
  end

endmodule

// File: rtl/seg7_scan.sv
// N-digit common-anode display scanner with frame-aligned double buffering,
// inter-digit dead time and leading-zero suppression.
//
// state | meaning
// BLANK | all anodes off, dead time before the next digit
// DRIVE | anode of digit idx on, segments show that digit
module seg7_scan
  import seg7_scan_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int DWELL_TICKS = 4,
  parameter int BLANK_TICKS = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scan_tick,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] data_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  lz_blank,
  output logic [N_DIGITS-1:0]   an,
  output logic [7:0]            seg,
  output logic                  frame_done
);

  localparam int MAX_TICKS = (DWELL_TICKS > BLANK_TICKS) ? DWELL_TICKS : BLANK_TICKS;
  localparam int TCW       = $clog2(MAX_TICKS + 1);
  localparam int IW        = $clog2(N_DIGITS);

  localparam logic [TCW-1:0] DWELL_TC = TCW'(DWELL_TICKS - 1);
  localparam logic [TCW-1:0] BLANK_TC = TCW'(BLANK_TICKS - 1);
  localparam logic [IW-1:0]  IDX_LAST = IW'(N_DIGITS - 1);

  scan_state_e           state_q, state_n;
  logic [TCW-1:0]        tick_q, tick_n;
  logic [IW-1:0]         idx_q, idx_n;
  logic                  wrap;

  logic [4*N_DIGITS-1:0] staging_data, shadow_data;
  logic [N_DIGITS-1:0]   staging_dp, shadow_dp;
  logic [N_DIGITS-1:0]   lz_mask;
  logic                  zero_run;

  logic [N_DIGITS-1:0]   an_n;
  logic [7:0]            seg_n;
  logic [3:0]            nib_sel;
  logic                  dp_sel;
  logic [7:0]            glyph_seg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BLANK;
      tick_q     <= '0;
      idx_q      <= '0;
      an         <= '1;
      seg        <= SEG_OFF;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_n;
      tick_q     <= tick_n;
      idx_q      <= idx_n;
      an         <= an_n;
      seg        <= seg_n;
      frame_done <= wrap;
    end
  end

  always_comb begin
    state_n = state_q;
    tick_n  = tick_q;
    idx_n   = idx_q;
    wrap    = 1'b0;
    if (scan_tick) begin
      case (state_q)
        BLANK: begin
          if (tick_q == BLANK_TC) begin
            state_n = DRIVE;
            tick_n  = '0;
          end else begin
            tick_n = tick_q + 1'b1;
          end
        end
        DRIVE: begin
          if (tick_q == DWELL_TC) begin
            state_n = BLANK;
            tick_n  = '0;
            if (idx_q == IDX_LAST) begin
              idx_n = '0;
              wrap  = 1'b1;
            end else begin
              idx_n = idx_q + 1'b1;
            end
          end else begin
            tick_n = tick_q + 1'b1;
          end
        end
        default: begin
          state_n = BLANK;
          tick_n  = '0;
        end
      endcase
    end
  end

  // Digit k is blank when every nibble from k up to the top digit is zero.
  always_comb begin
    zero_run = 1'b1;
    lz_mask  = '0;
    for (int k = N_DIGITS - 1; k > 0; k--) begin
      zero_run   = zero_run && (shadow_data[4*k +: 4] == 4'h0);
      lz_mask[k] = lz_blank && zero_run;
    end
  end

  assign nib_sel = shadow_data[int'(idx_n)*4 +: 4];
  assign dp_sel  = shadow_dp[idx_n];

  hex_to_seg7 u_dec (
    .nibble (nib_sel),
    .dp     (dp_sel),
    .seg    (glyph_seg)
  );

  // Outputs are computed from the next state so they register alongside it.
  always_comb begin
    an_n  = '1;
    seg_n = SEG_OFF;
    if (state_n == DRIVE) begin
      an_n[idx_n] = 1'b0;
      seg_n       = lz_mask[idx_n] ? {~dp_sel, 7'h7F} : glyph_seg;
    end
  end

  // A load coinciding with the wrap tick goes straight to the shadow.
  always_ff @(posedge clk) begin
    if (rst) begin
      staging_data <= '0;
      staging_dp   <= '0;
      shadow_data  <= '0;
      shadow_dp    <= '0;
    end else begin
      if (load) begin
        staging_data <= data_in;
        staging_dp   <= dp_in;
      end
      if (wrap) begin
        shadow_data <= load ? data_in : staging_data;
        shadow_dp   <= load ? dp_in   : staging_dp;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan: scans whole frames, checking every tick
// against expected {an, seg, frame_done} held in a scoreboard queue.
module tb_seg7_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scan_tick = 1'b0;
  logic        load = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0]  dp_in = '0;
  logic        lz_blank = 1'b0;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic        frame_done;

  int tests = 0;
  int fails = 0;
  logic [12:0] sb[$];

  logic [7:0] glyph [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  seg7_scan #(.N_DIGITS(4), .DWELL_TICKS(4), .BLANK_TICKS(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .scan_tick  (scan_tick),
    .load       (load),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .lz_blank   (lz_blank),
    .an         (an),
    .seg        (seg),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_seg(input logic [15:0] d, input logic [3:0] dp,
                                         input logic lz, input int k);
    logic [7:0]  s;
    logic [15:0] upper;
    upper = d >> (4*k);
    if (lz && k > 0 && upper == 16'h0) s = 8'hFF;
    else s = glyph[upper[3:0]];
    if (dp[k]) s[7] = 1'b0;
    return s;
  endfunction

  task automatic check(input string tag);
    logic [12:0] exp, obs;
    obs = {an, seg, frame_done};
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
    end else begin
      exp = sb.pop_front();
      assert (obs === exp) else begin
        fails++;
        $error("FAIL %s: observed an=%h seg=%h fd=%b, expected an=%h seg=%h fd=%b",
               tag, obs[12:9], obs[8:1], obs[0], exp[12:9], exp[8:1], exp[0]);
      end
    end
  endtask

  task automatic do_tick(input logic ld, input logic [15:0] ld_data, input logic [3:0] ld_dp,
                         input logic [12:0] exp, input string tag);
    @(negedge clk);
    scan_tick = 1'b1;
    load      = ld;
    if (ld) begin
      data_in = ld_data;
      dp_in   = ld_dp;
    end
    sb.push_back(exp);
    @(negedge clk);
    scan_tick = 1'b0;
    load      = 1'b0;
    check(tag);
    if (exp[0]) begin
      sb.push_back({exp[12:1], 1'b0});
      @(negedge clk);
      check("fd_pulse_width");
      repeat (2) @(negedge clk);
    end else begin
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic pulse_load(input logic [15:0] d, input logic [3:0] dp);
    @(negedge clk);
    load    = 1'b1;
    data_in = d;
    dp_in   = dp;
    @(negedge clk);
    load = 1'b0;
  endtask

  // One full frame starting from BLANK with tick_cnt 0.
  task automatic run_frame(input logic [15:0] d, input logic [3:0] dp, input string tag,
                           input logic mid_ld, input logic [15:0] mid_d, input logic [3:0] mid_dp,
                           input logic wrap_ld, input logic [15:0] wrap_d,
                           input logic frz, input logic [15:0] frz_d);
    logic [3:0] e_an;
    logic [7:0] e_seg;
    for (int k = 0; k < 4; k++) begin
      e_an  = ~(4'b0001 << k);
      e_seg = exp_seg(d, dp, lz_blank, k);
      do_tick(1'b0, '0, '0, {e_an, e_seg, 1'b0}, tag);
      if (k == 0 && frz) begin
        for (int c = 0; c < 100; c++) begin
          if (c == 50) begin
            load    = 1'b1;
            data_in = frz_d;
            dp_in   = 4'h0;
          end
          sb.push_back({e_an, e_seg, 1'b0});
          @(negedge clk);
          load = 1'b0;
          if (c % 10 == 0) check("freeze");
        end
        sb.delete();
      end
      if (k == 1 && mid_ld) begin
        pulse_load(~mid_d, ~mid_dp);
        pulse_load(mid_d, mid_dp);
      end
      for (int t = 0; t < 3; t++) do_tick(1'b0, '0, '0, {e_an, e_seg, 1'b0}, tag);
      do_tick((k == 3) && wrap_ld, wrap_d, 4'h0, {4'hF, 8'hFF, k == 3}, "blank");
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    sb.push_back({4'hF, 8'hFF, 1'b0});
    check("reset_init");
    rst = 1'b0;

    do_tick(1'b0, '0, '0, {4'b1110, 8'hC0, 1'b0}, "pre_rst_drive");
    do_tick(1'b1, 16'h4321, 4'hF, {4'b1110, 8'hC0, 1'b0}, "pre_rst_drive2");
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb.push_back({4'hF, 8'hFF, 1'b0});
      @(negedge clk);
      check("reset_hold");
    end
    rst = 1'b0;
    sb.push_back({4'hF, 8'hFF, 1'b0});
    @(negedge clk);
    check("reset_release");

    // staging was cleared by reset, so the first frame shows zeros
    run_frame(16'h0000, 4'h0, "frame_zero", 1'b1, 16'h1234, 4'h0, 1'b0, '0, 1'b0, '0);
    run_frame(16'h1234, 4'h0, "scan_order", 1'b1, 16'hABCD, 4'h1, 1'b0, '0, 1'b0, '0);
    run_frame(16'hABCD, 4'h1, "buffered",   1'b0, '0, '0, 1'b1, 16'h0F00, 1'b0, '0);
    run_frame(16'h0F00, 4'h0, "wrap_bypass", 1'b1, 16'h0070, 4'h0, 1'b0, '0, 1'b0, '0);
    lz_blank = 1'b1;
    run_frame(16'h0070, 4'h0, "lz_0070",    1'b1, 16'h0000, 4'h4, 1'b0, '0, 1'b0, '0);
    run_frame(16'h0000, 4'h4, "lz_0000",    1'b0, '0, '0, 1'b0, '0, 1'b1, 16'h5678);
    run_frame(16'h5678, 4'h0, "after_freeze", 1'b0, '0, '0, 1'b0, '0, 1'b0, '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
